dog_dt_rd: RTL and testbench
============================

# dog_dt_rd

Read-side feeder for the distance-transform write stage. Streams a 256x256 8-bit image from on-chip RAM, first row by row (pass 0) and then column by column (pass 1). Each line passes through a 13-tap sliding minimum filter (radius 6). The result is presented as a valid/data stream of exactly 262 samples per line: 6 warm-up samples followed by 256 centred results. This matches the downstream writer, which discards the first 6 samples of every line and transposes its addressing in pass 1.

## Interface
Parameters:
- PAD_VAL, 8'hff: value substituted for out-of-image samples, both left padding and right flush.
- GAP_CYCLES, 8: idle cycles between the last pass-0 slot and the first pass-1 slot. Minimum 3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that starts a 2-pass run. Ignored while busy.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  16  RAM address. Pass 0: {line, idx}. Pass 1: {idx, line}.
- rd_data  in  8  RAM read data. Valid exactly 1 cycle after rd_en.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- valid_out  out  1  output sample strobe, to the writer's wr_valid_in.
- data_out  out  8  filtered sample, to the writer's wr_data_in.
- done  out  1  1-cycle pulse on the final output sample of pass 1.

## Operation
- FSM states: IDLE, ROW, GAP, COL.
  - IDLE to ROW on start.
  - ROW to GAP after slot 261 of line 255.
  - GAP to COL after GAP_CYCLES cycles.
  - COL to IDLE after slot 261 of line 255.
- Counters:
  - line: 8 bits, 0..255.
  - slot: 9 bits, 0..261.
  - In ROW and COL, one slot is issued every cycle with no bubbles, including across line boundaries. This is mandatory because the writer advances its line on its own count.
- Slots 0..255 are read slots:
  - rd_en=1.
  - idx = slot[7:0].
  - The sample is rd_data.
- Slots 256..261 are pad slots:
  - rd_en=0.
  - The sample is PAD_VAL.
- Window: 13 taps, tap0 newest.
  - A sample tagged line-start (slot 0) loads tap0 with the sample and taps 1..12 with PAD_VAL, so there is no leakage from the previous line.
  - Any other sample shifts the taps.
- Output: unsigned min of taps 0..12.
  - Output k of a line equals min(s[k-12..k]), with s out of range = PAD_VAL.
  - Outputs 6..261 are therefore min(s[c-6..c+6]) for c = 0..255.
- Pass 1 reads the RAM contents that the writer produced in pass 0. GAP exists so the last row write commits before the first column read.
- Width rules: no arithmetic beyond counter increments. The 9-bit slot and 8-bit line wrap cleanly at terminal values.

## Timing
- Slot issued in cycle t: rd_en/rd_addr in t, rd_data in t+1, window updated at the end of t+1, valid_out/data_out registered in t+2. Pipeline latency is 2 cycles for both read slots and pad slots.
- valid_out is high for 262 consecutive cycles per line.
  - Lines are back to back within a pass: 256x262 consecutive valid cycles per pass.
  - In the gap between passes, valid_out drops for GAP_CYCLES cycles.
- done is asserted together with the final valid_out, i.e. 2 cycles after the last COL slot. busy falls the following cycle.
- A start pulse in the same cycle as done is ignored. A start pulse one cycle later is accepted.
- Reset values: rd_en=0, rd_addr=0, valid_out=0, data_out=0, done=0, busy=0, FSM=IDLE, all taps=PAD_VAL.
- Asynchronous reset mid-run aborts immediately to the reset values. The downstream writer must be reset with the same rst_n.

## Test plan
- Constant image, all 8'h40, full run: 512x262 valid samples. Data sequence per line is min-with-pad, so all outputs are 8'h40 because PAD_VAL=8'hff exceeds 8'h40. Exactly one done pulse. busy low after it.
- Single dark pixel: mem[{8'd10,8'd100}]=8'h00, all others 8'hff. In pass 0, line 10, outputs 6..261 = 0 for centres 94..106 and 8'hff elsewhere. All other lines are all 8'hff.
- Edge handling: row 0 = ramp s[i]=i. Line 0 output 6 (centre 0) = 0. Output 261 (centre 255) = 249.
- Line isolation: row 5 all 8'h00, row 6 all 8'hff. Every output of line 6 = 8'hff, including outputs 0..11.
- Address and handshake:
  - rd_addr in pass 1, line 3, slot 7 = 16'h0703.
  - rd_en is low on pad slots.
  - No valid_out gaps within a pass.
  - The gap is exactly GAP_CYCLES cycles.
  - A start pulse during busy is ignored.
- Reset mid-run: assert rst_n=0 during pass 0, line 50. All outputs are 0 immediately. After release and a new start, a complete correct run follows.

Source files
------------

// File: rtl/dog_dt_rd_if.sv
// Streaming interface of the distance-transform read feeder: start/status,
// RAM read port and the filtered sample stream towards the writer.
interface dog_dt_rd_if;
    logic        start;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        done;

    modport master (
        input  start, rd_data,
        output rd_en, rd_addr, busy, valid_out, data_out, done
    );

    modport slave (
        output start, rd_data,
        input  rd_en, rd_addr, busy, valid_out, data_out, done
    );
endinterface

// File: rtl/dog_dt_rd.sv
// Read-side feeder: streams a 256x256 image row-wise then column-wise through a
// 13-tap sliding minimum, emitting 262 samples per line (6 warm-up + 256 centred).
//
//   state | meaning
//   IDLE  | waiting for start
//   ROW   | pass 0, one slot per cycle, address {line, idx}
//   GAP   | idle cycles so the last row write lands before column reads
//   COL   | pass 1, one slot per cycle, address {idx, line}
module dog_dt_rd #(
    parameter logic [7:0] PAD_VAL    = 8'hff,
    parameter int         GAP_CYCLES = 8
) (
    input logic         clk,
    input logic         rst_n,
    dog_dt_rd_if.master bus
);

    localparam logic [8:0] SLOT_LAST = 9'd261;
    localparam logic [7:0] LINE_LAST = 8'd255;
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ROW, GAP, COL} state_t;

    state_t     state, state_nxt;
    logic [8:0] slot, slot_nxt;
    logic [7:0] line, line_nxt;
    logic [7:0] gap_cnt, gap_cnt_nxt;
    logic       issue, line_end, pass_end, accept;
    logic       s1_valid, s1_pad, s1_first, s1_last;
    logic [7:0] sample, win_min;
    logic [7:0] taps [13];
    logic [7:0] taps_nxt [13];
    logic       busy_r, valid_r, done_r;
    logic [7:0] data_r;

    assign issue    = (state == ROW) || (state == COL);
    assign line_end = (slot == SLOT_LAST);
    assign pass_end = line_end && (line == LINE_LAST);
    assign accept   = (state == IDLE) && bus.start && !busy_r;

    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        line_nxt    = line;
        gap_cnt_nxt = gap_cnt;
        if (issue) begin
            if (line_end) begin
                slot_nxt = '0;
                line_nxt = line + 8'd1;
            end else begin
                slot_nxt = slot + 9'd1;
            end
        end
        case (state)
            IDLE: if (accept) state_nxt = ROW;
            ROW: begin
                if (pass_end) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt = COL;
                else                 gap_cnt_nxt = gap_cnt - 8'd1;
            end
            COL: if (pass_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            slot    <= '0;
            line    <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            slot    <= slot_nxt;
            line    <= line_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    assign bus.rd_en   = issue && !slot[8];
    assign bus.rd_addr = (state == COL) ? {slot[7:0], line} : {line, slot[7:0]};

    // A line-start sample flushes the older taps so nothing leaks across lines.
    assign sample = s1_pad ? PAD_VAL : bus.rd_data;

    always_comb begin
        taps_nxt[0] = sample;
        for (int i = 1; i < 13; i++) begin
            taps_nxt[i] = s1_first ? PAD_VAL : taps[i-1];
        end
    end

    always_comb begin
        win_min = taps_nxt[0];
        for (int i = 1; i < 13; i++) begin
            if (taps_nxt[i] < win_min) win_min = taps_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pad   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            data_r   <= '0;
            busy_r   <= 1'b0;
            for (int i = 0; i < 13; i++) taps[i] <= PAD_VAL;
        end else begin
            s1_valid <= issue;
            s1_pad   <= slot[8];
            s1_first <= (slot == 9'd0);
            s1_last  <= (state == COL) && pass_end;
            valid_r  <= s1_valid;
            done_r   <= s1_last;
            if (s1_valid) begin
                data_r <= win_min;
                for (int i = 0; i < 13; i++) taps[i] <= taps_nxt[i];
            end
            if (accept)      busy_r <= 1'b1;
            else if (done_r) busy_r <= 1'b0;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.valid_out = valid_r;
    assign bus.data_out  = data_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_dog_dt_rd.sv
// Directed bench for dog_dt_rd: RAM and writer models, stream capture, and
// per-feature check tasks against a sliding-minimum reference.
module tb_dog_dt_rd;
    localparam int LN    = 262;
    localparam int PASS  = 256 * LN;
    localparam int TOTAL = 2 * PASS;

    logic clk;
    logic rst_n;
    dog_dt_rd_if bus ();

    dog_dt_rd #(.PAD_VAL(8'hff), .GAP_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  img0     [65536];
    logic [7:0]  wmem     [65536];
    logic [7:0]  exp0     [65536];
    logic [7:0]  cap_data [TOTAL];
    logic        cap_rden [TOTAL];
    logic [15:0] cap_addr [TOTAL];

    int   n_pass, n_chk;
    int   vcnt, low_cnt, done_cnt, done_vcnt;
    logic done_valid, seen, in_pass1, mon_en, mon_clr;
    logic p1_en, p2_en;
    logic [15:0] p1_addr, p2_addr;
    logic run_ok;

    // RAM: pass 0 reads the source image, pass 1 reads what the writer stored.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= in_pass1 ? wmem[bus.rd_addr] : img0[bus.rd_addr];
    end

    // Stream capture plus pass-0 writer (drops the 6 warm-up samples).
    always @(negedge clk) begin
        p1_en   <= bus.rd_en;
        p1_addr <= bus.rd_addr;
        p2_en   <= p1_en;
        p2_addr <= p1_addr;
        if (mon_clr) begin
            vcnt     <= 0;
            low_cnt  <= 0;
            done_cnt <= 0;
            done_vcnt <= -1;
            done_valid <= 1'b0;
            seen     <= 1'b0;
            in_pass1 <= 1'b0;
        end else if (mon_en) begin
            if (bus.valid_out) begin
                if (vcnt < TOTAL) begin
                    cap_data[vcnt] <= bus.data_out;
                    cap_rden[vcnt] <= p2_en;
                    cap_addr[vcnt] <= p2_addr;
                end
                if (vcnt < PASS && (vcnt % LN) >= 6)
                    wmem[16'(((vcnt / LN) << 8) + (vcnt % LN) - 6)] <= bus.data_out;
                if (vcnt + 1 == PASS) in_pass1 <= 1'b1;
                vcnt <= vcnt + 1;
                seen <= 1'b1;
            end else if (seen && done_cnt == 0) begin
                low_cnt <= low_cnt + 1;
            end
            if (bus.done) begin
                done_cnt   <= done_cnt + 1;
                done_vcnt  <= vcnt;
                done_valid <= bus.valid_out;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk) #1 bus.start = 1'b1;
        @(posedge clk) #1 bus.start = 1'b0;
    endtask

    task automatic load_image();
        for (int a = 0; a < 65536; a++) img0[a] = 8'h40;
        for (int i = 0; i < 256; i++) begin
            img0[{8'd0, 8'(i)}] = 8'(i);
            img0[{8'd5, 8'(i)}] = 8'h00;
            img0[{8'd6, 8'(i)}] = 8'hff;
        end
        img0[{8'd10, 8'd100}] = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        mon_en = 1'b0;
        mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.rd_en, bus.rd_addr, bus.valid_out, bus.data_out, bus.done, bus.busy} !== 29'd0)
            $display("FAIL reset_outputs: got en=%b addr=%h v=%b d=%h done=%b busy=%b, want all 0",
                     bus.rd_en, bus.rd_addr, bus.valid_out, bus.data_out, bus.done, bus.busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic test_busy_start_and_abort();
        bit found;
        pulse_start();
        n_chk++;
        if ({bus.busy, bus.rd_en, bus.rd_addr} !== {2'b11, 16'h0000})
            $display("FAIL first_slot: got busy=%b en=%b addr=%h, want 1 1 0000", bus.busy, bus.rd_en, bus.rd_addr);
        else n_pass++;
        repeat (256) @(posedge clk) #1;
        n_chk++;
        if (bus.rd_en !== 1'b0)
            $display("FAIL pad_slot_rd_en: got %b want 0", bus.rd_en);
        else n_pass++;
        repeat (44) @(posedge clk) #1;
        n_chk++;
        if ({bus.rd_en, bus.rd_addr} !== {1'b1, 16'h0126})
            $display("FAIL slot300_addr: got en=%b addr=%h, want 1 0126", bus.rd_en, bus.rd_addr);
        else n_pass++;
        pulse_start();
        repeat (98) @(posedge clk) #1;
        n_chk++;
        if ({bus.busy, bus.rd_en, bus.rd_addr} !== {2'b11, 16'h018a})
            $display("FAIL start_while_busy: got busy=%b en=%b addr=%h, want 1 1 018a", bus.busy, bus.rd_en, bus.rd_addr);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (bus.rd_en && bus.rd_addr[15:8] == 8'd50) found = 1'b1;
            else @(posedge clk) #1;
        end
        n_chk++;
        if (!found) $display("FAIL reach_line50: got timeout, want line 50 reached");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.rd_en, bus.rd_addr, bus.valid_out, bus.data_out, bus.done, bus.busy} !== 29'd0)
            $display("FAIL abort_outputs: got en=%b addr=%h v=%b d=%h done=%b busy=%b, want all 0",
                     bus.rd_en, bus.rd_addr, bus.valid_out, bus.data_out, bus.done, bus.busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_full_run();
        int cyc;
        @(negedge clk) #1 mon_clr = 1'b1;
        @(negedge clk) #1 begin mon_clr = 1'b0; mon_en = 1'b1; end
        pulse_start();
        cyc = 0;
        @(negedge clk);
        while (!bus.done && cyc < 140000) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (!bus.done) begin
            $display("FAIL done_timeout: got no done after %0d cycles, want done", cyc);
            run_ok = 1'b0;
        end else begin
            n_pass++;
            run_ok = 1'b1;
        end
        if (run_ok) begin
            n_chk++;
            if (bus.busy !== 1'b1) $display("FAIL busy_at_done: got %b want 1", bus.busy);
            else n_pass++;
            #1 begin mon_en = 1'b0; bus.start = 1'b1; end
            @(negedge clk);
            n_chk++;
            if ({bus.busy, bus.done} !== 2'b00)
                $display("FAIL start_on_done: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
            else n_pass++;
            @(negedge clk);
            n_chk++;
            if (bus.busy !== 1'b1) $display("FAIL start_after_done: got busy=%b want 1", bus.busy);
            else n_pass++;
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        n_chk++;
        if (vcnt !== TOTAL) $display("FAIL valid_count: got %0d want %0d", vcnt, TOTAL);
        else n_pass++;
        n_chk++;
        if (done_cnt !== 1) $display("FAIL done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_chk++;
        if (done_vcnt !== TOTAL - 1 || done_valid !== 1'b1)
            $display("FAIL done_position: got sample %0d valid=%b, want %0d 1", done_vcnt, done_valid, TOTAL - 1);
        else n_pass++;
        n_chk++;
        if (low_cnt !== 8) $display("FAIL gap_cycles: got %0d idle cycles, want 8", low_cnt);
        else n_pass++;
    endtask

    task automatic test_pass(input int p);
        for (int l = 0; l < 256; l++) begin
            bit bad;
            int bk;
            logic [7:0] be, ba;
            bad = 1'b0;
            bk = 0; be = 0; ba = 0;
            for (int k = 0; k < LN; k++) begin
                logic [7:0] e, s;
                logic [15:0] ea;
                logic en;
                int idx;
                e = 8'hff;
                for (int j = k - 12; j <= k; j++) begin
                    if (j >= 0 && j < 256) begin
                        s = (p == 0) ? img0[{8'(l), 8'(j)}] : exp0[{8'(j), 8'(l)}];
                        if (s < e) e = s;
                    end
                end
                if (p == 0 && k >= 6) exp0[{8'(l), 8'(k - 6)}] = e;
                idx = p * PASS + l * LN + k;
                en = (k < 256);
                ea = (p == 0) ? {8'(l), 8'(k)} : {8'(k), 8'(l)};
                if (!bad && (cap_data[idx] !== e || cap_rden[idx] !== en || (en && cap_addr[idx] !== ea))) begin
                    bad = 1'b1; bk = k; be = e; ba = cap_data[idx];
                end
            end
            n_chk++;
            if (bad)
                $display("FAIL pass%0d_line%0d: slot %0d got data=%h en=%b addr=%h, want data=%h",
                         p, l, bk, ba, cap_rden[p * PASS + l * LN + bk], cap_addr[p * PASS + l * LN + bk], be);
            else n_pass++;
        end
    endtask

    task automatic test_edges();
        logic [7:0] got, want;
        int idx;
        int dir_tab [11][2];
        logic [7:0] want_tab [11];
        bit ok;
        dir_tab = '{'{0, 6}, '{0, 261}, '{10, 99}, '{10, 100}, '{10, 112}, '{10, 113},
                    '{5, 0}, '{256 + 50, 17}, '{256 + 50, 18}, '{256 + 100, 22}, '{256 + 100, 23}};
        want_tab = '{8'h00, 8'hf9, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40};
        for (int i = 0; i < 11; i++) begin
            idx = dir_tab[i][0] * LN + dir_tab[i][1];
            got = cap_data[idx];
            want = want_tab[i];
            n_chk++;
            if (got !== want)
                $display("FAIL edge_line%0d_out%0d: got %h want %h", dir_tab[i][0], dir_tab[i][1], got, want);
            else n_pass++;
        end
        ok = 1'b1;
        for (int k = 0; k < 12; k++) if (cap_data[6 * LN + k] !== 8'hff) ok = 1'b0;
        n_chk++;
        if (!ok) $display("FAIL line6_isolation: got %h at out0, want ff on outputs 0..11", cap_data[6 * LN]);
        else n_pass++;
        n_chk++;
        if (cap_addr[PASS + 3 * LN + 7] !== 16'h0703)
            $display("FAIL col_addr: got %h want 0703", cap_addr[PASS + 3 * LN + 7]);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_chk = 0;
        run_ok = 1'b0;
        bus.start = 1'b0;
        load_image();
        test_reset();
        test_busy_start_and_abort();
        test_full_run();
        test_stream();
        test_pass(0);
        test_pass(1);
        test_edges();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
